// File: rtl/bypass_tag_pipe_pkg.sv
// bypass_pkg: tag layout, opcodes and special registers shared by the tag pipe and the forwarding unit.
package bypass_pkg;
  localparam int WORD  = 32;
  localparam int RBITS = 5;
  localparam logic [RBITS-1:0] EXC_REG  = 5'd30;
  localparam logic [RBITS-1:0] LINK_REG = 5'd31;
  localparam int RA_LSB  = 0;
  localparam int RB_LSB  = 5;
  localparam int RW_LSB  = 10;
  localparam int LW_BIT  = 29;
  localparam int SW_BIT  = 30;
  localparam int EXC_BIT = 31;
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;
  // A zero destination never writes, so it also never claims EXC_REG.
  function automatic logic [WORD-1:0] mk_tag(input logic [RBITS-1:0] a, input logic [RBITS-1:0] b,
                                             input logic [RBITS-1:0] w, input logic lw,
                                             input logic sw, input logic exc);
    logic [WORD-1:0] t;
    t = '0;
    t[RA_LSB+:RBITS] = a;
    t[RB_LSB+:RBITS] = b;
    t[RW_LSB+:RBITS] = w;
    t[LW_BIT]  = lw;
    t[SW_BIT]  = sw;
    t[EXC_BIT] = exc && (w != '0);
    return t;
  endfunction
endpackage

// File: rtl/bypass_tag_pipe_if.sv
// bypass_tag_pipe_if: F/D instruction, pipeline controls and the three bypass tags.
interface bypass_tag_pipe_if;
  import bypass_pkg::*;
  logic [WORD-1:0] fd_insn;
  logic            fd_valid;
  logic            freeze;
  logic            stall;
  logic            flush;
  logic            x_ovf;
  logic [WORD-1:0] dxb;
  logic [WORD-1:0] xmb;
  logic [WORD-1:0] mwb;
  modport master(output fd_insn, fd_valid, freeze, stall, flush, x_ovf, input dxb, xmb, mwb);
  modport slave(input fd_insn, fd_valid, freeze, stall, flush, x_ovf, output dxb, xmb, mwb);
endinterface

// File: rtl/bypass_tag_pipe_decode.sv
// bypass_tag_decode: combinational F/D instruction to bypass-tag decode.
module bypass_tag_decode
  import bypass_pkg::*;
(
  input  logic [WORD-1:0] i_insn,
  input  logic            i_valid,
  output logic [WORD-1:0] o_tag
);
  logic [4:0]       w_op;
  logic [RBITS-1:0] w_rd, w_rs, w_rt;
  logic             w_unused;
  assign w_op = i_insn[31:27];
  assign w_rd = i_insn[26:22];
  assign w_rs = i_insn[21:17];
  assign w_rt = i_insn[16:12];
  assign w_unused = &{1'b0, i_insn[11:0]};
  always_comb begin
    o_tag = '0;
    if (i_valid)
      case (w_op)
        OP_RTYPE: o_tag = mk_tag(w_rs, w_rt, w_rd, 1'b0, 1'b0, 1'b0);
        OP_ADDI:  o_tag = mk_tag(w_rs, '0, w_rd, 1'b0, 1'b0, 1'b0);
        OP_LW:    o_tag = mk_tag(w_rs, '0, w_rd, 1'b1, 1'b0, 1'b0);
        OP_SW:    o_tag = mk_tag(w_rs, w_rd, '0, 1'b0, 1'b1, 1'b0);
        OP_BNE,
        OP_BLT:   o_tag = mk_tag(w_rd, w_rs, '0, 1'b0, 1'b0, 1'b0);
        OP_JR:    o_tag = mk_tag(w_rd, '0, '0, 1'b0, 1'b0, 1'b0);
        OP_JAL:   o_tag = mk_tag('0, '0, LINK_REG, 1'b0, 1'b0, 1'b0);
        OP_SETX:  o_tag = mk_tag('0, '0, EXC_REG, 1'b0, 1'b0, 1'b1);
        OP_BEX:   o_tag = mk_tag(EXC_REG, '0, '0, 1'b0, 1'b0, 1'b0);
        default:  o_tag = '0;
      endcase
  end
endmodule

// File: rtl/bypass_tag_pipe.sv
// bypass_tag_pipe: D/X, X/M, M/W bypass-tag latches with freeze/stall/flush priority
// and X-stage overflow rewrite of the destination to EXC_REG.
module bypass_tag_pipe
  import bypass_pkg::*;
(
  input logic               clock,
  input logic               reset,
  bypass_tag_pipe_if.slave  bus
);
  logic [WORD-1:0] r_dxb, r_xmb, r_mwb;
  logic [WORD-1:0] w_dec, w_adv;
  bypass_tag_decode u_dec (
    .i_insn  (bus.fd_insn),
    .i_valid (bus.fd_valid),
    .o_tag   (w_dec)
  );
  // Overflow redirects a real write to EXC_REG; a zero destination stays silent.
  always_comb begin
    w_adv = r_dxb;
    if (bus.x_ovf && r_dxb[RW_LSB+:RBITS] != '0) begin
      w_adv[RW_LSB+:RBITS] = EXC_REG;
      w_adv[EXC_BIT]       = 1'b1;
    end
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_dxb <= '0;
      r_xmb <= '0;
      r_mwb <= '0;
    end else if (!bus.freeze) begin
      r_mwb <= r_xmb;
      r_xmb <= bus.stall ? '0 : w_adv;
      r_dxb <= bus.stall ? r_dxb : (bus.flush ? '0 : w_dec);
    end
  assign bus.dxb = r_dxb;
  assign bus.xmb = r_xmb;
  assign bus.mwb = r_mwb;
endmodule

// File: tb/tb_bypass_tag_pipe.sv
// tb_bypass_tag_pipe: directed plan checks plus randomized traffic against a behavioural model.
module tb_bypass_tag_pipe;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  logic [31:0] m_d = '0, m_x = '0, m_m = '0;
  bypass_tag_pipe_if bus ();
  bypass_tag_pipe dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ins(input int op, input int rd, input int rs, input int rt);
    logic [31:0] v;
    v = (op << 27) | (rd << 22) | (rs << 17) | (rt << 12);
    return v;
  endfunction

  function automatic logic [31:0] ref_tag(input logic [31:0] i, input logic v);
    int op, rd, rs, rt, a, b, w;
    bit lw, sw, ex;
    bit [4:0] fa, fb, fw;
    op = int'(i >> 27); rd = int'((i >> 22) & 31); rs = int'((i >> 17) & 31); rt = int'((i >> 12) & 31);
    a = 0; b = 0; w = 0; lw = 0; sw = 0; ex = 0;
    if (v) begin
      if (op == 0)       begin a = rs; b = rt; w = rd; end
      else if (op == 5)  begin a = rs; w = rd; end
      else if (op == 8)  begin a = rs; w = rd; lw = 1; end
      else if (op == 7)  begin a = rs; b = rd; sw = 1; end
      else if (op == 2 || op == 6) begin a = rd; b = rs; end
      else if (op == 4)  a = rd;
      else if (op == 3)  w = 31;
      else if (op == 21) begin w = 30; ex = 1; end
      else if (op == 22) a = 30;
    end
    if (w == 0) ex = 0;
    fa = a[4:0]; fb = b[4:0]; fw = w[4:0];
    return {ex, sw, lw, 14'b0, fw, fb, fa};
  endfunction

  task automatic model_step();
    logic [31:0] nx;
    if (!reset) begin
      m_d = '0; m_x = '0; m_m = '0;
    end else if (bus.freeze) begin
    end else if (bus.stall) begin
      m_m = m_x; m_x = '0;
    end else begin
      nx = m_d;
      if (bus.x_ovf && ((m_d >> 10) & 31) != 0) nx = (m_d & ~32'h0000_7C00) | (32'd30 << 10) | 32'h8000_0000;
      m_m = m_x; m_x = nx;
      m_d = bus.flush ? 32'h0 : ref_tag(bus.fd_insn, bus.fd_valid);
    end
  endtask

  task automatic tick(input logic [31:0] insn, input logic v, input logic frz, input logic stl,
                      input logic fl, input logic ovf);
    bus.fd_insn = insn; bus.fd_valid = v; bus.freeze = frz;
    bus.stall = stl; bus.flush = fl; bus.x_ovf = ovf;
    @(posedge clock);
    model_step();
    #1;
    check("dxb_model", bus.dxb, m_d);
    check("xmb_model", bus.xmb, m_x);
    check("mwb_model", bus.mwb, m_m);
  endtask

  task automatic bubble();
    tick('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic dec(input logic [31:0] insn);
    tick(insn, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int ops[12] = '{0, 5, 8, 7, 2, 6, 4, 3, 21, 22, 1, 13};
    logic [31:0] add3, lw4, add5;
    add3 = ins(0, 3, 1, 2);
    lw4  = ins(8, 4, 5, 0);
    add5 = ins(0, 5, 4, 4);
    for (int i = 0; i < 3; i++) begin
      tick($urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      check("reset_dxb", bus.dxb, 32'h0);
      check("reset_xmb", bus.xmb, 32'h0);
      check("reset_mwb", bus.mwb, 32'h0);
    end
    reset = 1'b1;
    dec(add3);  check("add_dxb", bus.dxb, 32'h0000_0C41);
    bubble();   check("add_xmb", bus.xmb, 32'h0000_0C41);
    bubble();   check("add_mwb", bus.mwb, 32'h0000_0C41);
    dec(lw4);             check("lw_dec",   bus.dxb, 32'h2000_1005);
    dec(ins(7, 6, 7, 0)); check("sw_dec",   bus.dxb, 32'h4000_00C7);
    dec(ins(3, 0, 0, 0)); check("jal_dec",  bus.dxb, 32'h0000_7C00);
    dec(ins(21, 0, 0, 0)); check("setx_dec", bus.dxb, 32'h8000_7800);
    dec(ins(22, 0, 0, 0)); check("bex_dec",  bus.dxb, 32'h0000_001E);
    dec(ins(0, 0, 1, 2)); check("r0_dec",   bus.dxb, 32'h0000_0041);
    dec(lw4);
    dec(add5);
    check("pre_stall_xmb", bus.xmb, 32'h2000_1005);
    tick(ins(5, 9, 9, 0), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("stall_dxb", bus.dxb, 32'h0000_1484);
    check("stall_xmb", bus.xmb, 32'h0);
    check("stall_mwb", bus.mwb, 32'h2000_1005);
    bubble();   check("unstall_xmb", bus.xmb, 32'h0000_1484);
    dec(add3);
    tick(add3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("flush_dxb", bus.dxb, 32'h0);
    check("flush_xmb", bus.xmb, 32'h0000_0C41);
    dec(add3);
    tick(ins(3, 0, 0, 0), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("flush_stall_dxb", bus.dxb, 32'h0000_0C41);
    check("flush_stall_xmb", bus.xmb, 32'h0);
    dec(add3);
    tick('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovf_xmb", bus.xmb, 32'h8000_7841);
    dec(ins(0, 0, 1, 2));
    tick('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovf_r0_xmb", bus.xmb, 32'h0000_0041);
    dec(lw4);
    dec(add5);
    dec(add3);
    for (int i = 0; i < 4; i++) begin
      tick($urandom, 1'b1, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
      check("freeze_dxb", bus.dxb, 32'h0000_0C41);
      check("freeze_xmb", bus.xmb, 32'h0000_1484);
      check("freeze_mwb", bus.mwb, 32'h2000_1005);
    end
    for (int i = 0; i < 400; i++) begin
      logic [31:0] r;
      r = ins(ops[$urandom_range(0, 11)], $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) r = $urandom;
      tick(r, $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0);
    end
    dec(add3);
    dec(add5);
    dec(lw4);
    #2;
    reset = 1'b0;
    m_d = '0; m_x = '0; m_m = '0;
    #1;
    check("async_dxb", bus.dxb, 32'h0);
    check("async_xmb", bus.xmb, 32'h0);
    check("async_mwb", bus.mwb, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
